// File: rtl/mult4_serial_pkg.sv
// mult4_pkg: shared state encoding and sizes for the serial 4x4 multiplier
package mult4_pkg;
    localparam int MULT4_STEPS = 4;
    localparam int MULT4_W = 4;
    typedef enum logic [1:0] {IDLE = 2'b00, CALC = 2'b01, DONE = 2'b10} state_t;
endpackage

// File: rtl/mult4_serial_if.sv
// mult4_serial_if: operand-in / product-out valid-ready bundle
interface mult4_serial_if;
    import mult4_pkg::*;
    logic in_valid;
    logic in_ready;
    logic [MULT4_W-1:0] a;
    logic [MULT4_W-1:0] b;
    logic out_valid;
    logic out_ready;
    logic [2*MULT4_W-1:0] prod;
    modport master(output in_valid, a, b, out_ready, input in_ready, out_valid, prod);
    modport slave(input in_valid, a, b, out_ready, output in_ready, out_valid, prod);
endinterface

// File: rtl/soma4bit.sv
// soma4bit: 4-bit ripple-carry adder, carry-in tied low
module soma4bit (
    input  logic [3:0] a_i,
    input  logic [3:0] b_i,
    output logic [3:0] s_o,
    output logic       c_out_o
);
    logic [4:0] c;
    assign c[0] = 1'b0;
    for (genvar i = 0; i < 4; i++) begin : g_fa
        assign s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
        assign c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
    assign c_out_o = c[4];
endmodule

// File: rtl/mult4_serial.sv
// mult4_serial: shift-and-add 4x4 multiplier on one soma4bit; MULT4_ZERO_SKIP_EN bypasses CALC for zero operands
module mult4_serial
    import mult4_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    mult4_serial_if.slave bus
);
    state_t               state_q;
    logic [MULT4_W-1:0]   acc_q, q_q, m_q, s_d, addend_d;
    logic                 c_d;
    logic [1:0]           step_q;
    logic [2*MULT4_W-1:0] prod_q, shift_d;

    assign addend_d = q_q[0] ? m_q : '0;

    soma4bit u_add (
        .a_i     (acc_q),
        .b_i     (addend_d),
        .s_o     (s_d),
        .c_out_o (c_d)
    );

    // carry lands in bit 7 so the 9-bit {c,s,q} shifts right without losing it
    assign shift_d = {c_d, s_d, q_q[MULT4_W-1:1]};

    // control FSM, datapath registers and the registered product
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            acc_q   <= '0;
            q_q     <= '0;
            m_q     <= '0;
            step_q  <= '0;
            prod_q  <= '0;
        end else begin
            case (state_q)
                IDLE: if (bus.in_valid) begin
                    m_q    <= bus.a;
                    q_q    <= bus.b;
                    acc_q  <= '0;
                    step_q <= '0;
`ifdef MULT4_ZERO_SKIP_EN
                    if (bus.a == '0 || bus.b == '0) begin
                        state_q <= DONE;
                        prod_q  <= '0;
                    end else begin
                        state_q <= CALC;
                    end
`else
                    state_q <= CALC;
`endif
                end
                CALC: begin
                    {acc_q, q_q} <= shift_d;
                    step_q       <= step_q + 2'd1;
                    if (step_q == 2'(MULT4_STEPS - 1)) begin
                        state_q <= DONE;
                        prod_q  <= shift_d;
                    end
                end
                DONE: if (bus.out_ready) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.in_ready  = (state_q == IDLE);
    assign bus.out_valid = (state_q == DONE);
    assign bus.prod      = prod_q;
endmodule

// File: tb/tb_mult4_serial.sv
// tb_mult4_serial: scoreboard bench for mult4_serial against a plain a*b model
module tb_mult4_serial;
    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mult4_serial_if bus();
    mult4_serial dut (.clk(clk), .rst_n(rst_n), .bus(bus));

    typedef struct {
        logic [7:0] p;
        int         c;
        int         lat;
    } exp_t;

    exp_t exp_q[$];
    exp_t e_in;
    int   cyc = 0;
    int   passed = 0;
    int   total = 0;
    int   last_acc = -1;
    bit   took = 0;
    bit   seen = 0;
    bit   b2b = 0;
    bit   rnd_or = 0;

    task automatic chk(input bit ok, input string n, input int act, input int req);
        total++;
        if (ok) passed++;
        else $display("FAIL %s: got %0d expected %0d (cycle %0d)", n, act, req, cyc);
    endtask

    function automatic int lat_for(input logic [3:0] x, input logic [3:0] y);
`ifdef MULT4_ZERO_SKIP_EN
        return (x == 0 || y == 0) ? 1 : 5;
`else
        return 5;
`endif
    endfunction

    always @(posedge clk) cyc++;

    always @(posedge clk) if (rnd_or) begin
        #1 bus.out_ready = 1'($urandom_range(0, 1));
    end

    // input monitor: every accepted operand pair becomes an expected product
    always @(negedge clk) if (rst_n && bus.in_valid && bus.in_ready) begin
        e_in.p   = {4'b0, bus.a} * {4'b0, bus.b};
        e_in.c   = cyc;
        e_in.lat = lat_for(bus.a, bus.b);
        if (b2b && last_acc >= 0) chk(cyc - last_acc == 6, "accept_spacing", cyc - last_acc, 6);
        last_acc = cyc;
        exp_q.push_back(e_in);
    end

    // output monitor: compare presented products with the scoreboard head
    always @(negedge clk) if (rst_n) begin
        if (took) begin
            chk(!bus.out_valid, "valid_one_cycle", bus.out_valid, 0);
            took = 0;
        end
        if (bus.out_valid) begin
            chk(!bus.in_ready, "in_ready_low_done", bus.in_ready, 0);
            if (exp_q.size() == 0) begin
                chk(0, "unexpected_out", bus.prod, -1);
            end else begin
                if (!seen) begin
                    chk(cyc - exp_q[0].c == exp_q[0].lat, "latency", cyc - exp_q[0].c, exp_q[0].lat);
                    seen = 1;
                end
                chk(bus.prod == exp_q[0].p, "prod", bus.prod, exp_q[0].p);
                if (bus.out_ready) begin
                    void'(exp_q.pop_front());
                    seen = 0;
                    took = 1;
                end
            end
        end
    end

    task automatic send(input logic [3:0] x, input logic [3:0] y, input bit hold);
        int n = 0;
        @(posedge clk); #1;
        bus.in_valid = 1'b1;
        bus.a = x;
        bus.b = y;
        while (!bus.in_ready && n < 100) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 100) chk(0, "accept_timeout", n, 100);
        @(posedge clk); #1;
        if (!hold) bus.in_valid = 1'b0;
        bus.a = 4'($urandom);
        bus.b = 4'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while (!(exp_q.size() == 0 && bus.in_ready) && n < 300) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 300) chk(0, "drain_timeout", exp_q.size(), 0);
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int n;
        bus.in_valid = 1'b0;
        bus.a = 4'd0;
        bus.b = 4'd0;
        bus.out_ready = 1'b1;
        #1;
        chk(!bus.out_valid, "rst_out_valid", bus.out_valid, 0);
        chk(bus.in_ready, "rst_in_ready", bus.in_ready, 1);
        chk(bus.prod == 8'd0, "rst_prod", bus.prod, 0);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b1;

        send(4'd4, 4'd2, 0);  drain();
        send(4'd15, 4'd15, 0); drain();
        send(4'd10, 4'd6, 0); drain();

        bus.out_ready = 1'b0;
        send(4'd1, 4'd9, 0);
        n = 0;
        while (!bus.out_valid && n < 20) begin
            @(posedge clk); #1;
            n++;
        end
        if (n >= 20) chk(0, "bp_valid_timeout", n, 20);
        bus.in_valid = 1'b1;
        bus.a = 4'd3;
        bus.b = 4'd3;
        @(posedge clk); #1;
        bus.in_valid = 1'b0;
        repeat (2) begin
            @(posedge clk); #1;
        end
        bus.out_ready = 1'b1;
        drain();

        send(4'd0, 4'd9, 0); drain();
        send(4'd7, 4'd0, 0); drain();

        send(4'd5, 4'd5, 0);
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk(!bus.out_valid, "abort_out_valid", bus.out_valid, 0);
        chk(bus.prod == 8'd0, "abort_prod", bus.prod, 0);
        chk(bus.in_ready, "abort_in_ready", bus.in_ready, 1);
        exp_q.delete();
        seen = 0;
        took = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send(4'd3, 4'd2, 0); drain();

        b2b = 1;
        last_acc = -1;
        for (int i = 0; i < 16; i++) send(4'($urandom_range(1, 15)), 4'($urandom_range(1, 15)), 1);
        bus.in_valid = 1'b0;
        drain();
        b2b = 0;

        rnd_or = 1;
        for (int i = 0; i < 24; i++) send(4'($urandom), 4'($urandom), 0);
        drain();
        rnd_or = 0;
        @(posedge clk); #2;
        bus.out_ready = 1'b1;
        drain();

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
